tcn_fifo_drain_decoder: RTL and testbench
=========================================

// Module: tcn_fifo_drain_decoder
// PURPOSE
// Read-side counterpart of the TCN circular-FIFO address encoder.
// On start, drains the whole TCN activation ring buffer to a valid/ready output stream in
// logical (oldest-first) order. It undoes the ring rotation, physical -> logical.
// Keeps its own FIFO pointer, updated by the same update-pulse protocol as the encoder.
// Sits between activation memory read port and the readback/DMA path.
// PARAMETERS
// ADDR_W  14  activation memory address width (16384 words)
// DATA_W  32  activation memory word width
// PORTS
// clk                      in   1       clock
// reset                    in   1       async active-low reset
// start                    in   1       1-cycle pulse: begin drain (ignored while busy)
// FIFO_TCN_active          in   1       1: ring rotation applied; 0: linear drain from addr 0
// FIFO_TCN_total_blocks    in   ADDR_W  number of blocks in ring
// FIFO_TCN_block_size      in   16      words per block
// FIFO_TCN_update_pointer  in   1       pointer-advance pulse (same source as encoder)
// mem_rd_en                out  1       memory read strobe
// mem_rd_addr              out  ADDR_W  physical read address
// mem_rd_data              in   DATA_W  read data, valid exactly 1 cycle after mem_rd_en
// out_valid                out  1       stream valid
// out_ready                in   1       stream ready
// out_data                 out  DATA_W  drained word
// out_logical_addr         out  ADDR_W  logical (time-ordered) index of out_data
// out_last                 out  1       marks final word of drain
// busy                     out  1       drain in progress (start..done)
// done                     out  1       1-cycle pulse after last word accepted
// BEHAVIOUR
// - Reset: all outputs 0; FIFO_pointer=0; FSM=IDLE; buffer empty; update pulse reg=0.
// - Pointer: update pulse registered 1 cycle.
//   Registered pulse advances FIFO_pointer: +1, wraps to 0 when pointer==total_blocks-1.
//   Runs in every FSM state; a drain in progress keeps its start snapshot.
// - At start (IDLE only), snapshot, all arithmetic truncated to ADDR_W bits:
//   N   = total_blocks*block_size.
//   cur = FIFO_pointer*block_size when active, else 0.
//   P0  = (cur==0) ? 0 : N-cur.
//   The encoder maps logical L to physical (L-cur) mod N; this block inverts that map.
// - FSM IDLE -> DRAIN on start (busy=1 next cycle).
//   If N==0: no reads; DRAIN -> DONE immediately.
// - DRAIN: issue read when issued-but-unaccepted words < 2 (2-entry output buffer + in-flight credit).
//   Physical addr starts at P0, +1 per read, wraps N-1 -> 0.
//   Logical counter starts at 0, +1 per read. Exactly N reads issued. Then -> FLUSH.
// - FLUSH: wait until buffer empty and no read in flight, then -> DONE.
// - DONE: done=1 for one cycle, busy=0, -> IDLE.
// - Output buffer: 2-entry FIFO of {data, logical addr, last}; data captured the cycle after mem_rd_en.
//   out_last=1 on logical index N-1.
//   Transfer on out_valid&&out_ready.
//   out_* hold stable while valid && !ready. Never drops or duplicates a word.
// - Throughput: 1 word/cycle with out_ready held 1.
//   First out_valid 2 cycles after start (read issue, data capture).
// - start while busy: ignored. Simultaneous start + update pulse: snapshot uses the pre-update pointer.
// - Async reset mid-drain: abort immediately; no done pulse; buffer flushed.
// TESTING
// 1. active=1, blocks=4, bsize=3, one update pulse (ptr=1), start, ready=1.
//    -> rd addrs 9,10,11,0..8; logical 0..11; last on 11; done once; 13 cycles start->last.
// 2. Same config, active=0 -> rd addrs 0..11 in order; logical==physical.
// 3. blocks=4, bsize=3, four update pulses (ptr wraps to 0) -> P0=0; addrs 0..11.
// 4. Backpressure: out_ready toggles 1,0,0,1,...
//    -> mem_rd_en stalls; <=2 words outstanding; data sequence intact; out_* stable while stalled.
// 5. blocks=0 -> busy 1 cycle, done pulse, zero mem_rd_en, no out_valid.
//    Second start during a drain: ignored.
// 6. Reset low mid-drain after 5 words -> all outputs 0 same cycle.
//    After release, new drain completes normally with ptr=0.

Source files
------------

// File: rtl/tcn_fifo_drain_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tcn_fifo_drain_decoder
//  Purpose  : Read-side counterpart of the TCN circular-FIFO address encoder.
//             On a start pulse it walks the whole activation ring buffer and
//             streams every word out in logical (oldest-first) order. It undoes
//             the encoder's ring rotation, physical <- logical. It keeps its own
//             copy of the FIFO pointer and advances it from the same
//             update-pulse source as the encoder.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                      in   1       clock
//    reset                    in   1       asynchronous reset, active low
//    start                    in   1       one-cycle pulse, begins a drain
//                                          (ignored unless idle)
//    FIFO_TCN_active          in   1       1: undo ring rotation, 0: linear
//    FIFO_TCN_total_blocks    in   ADDR_W  number of blocks in the ring
//    FIFO_TCN_block_size      in   16      words per block
//    FIFO_TCN_update_pointer  in   1       pointer-advance pulse
//    mem_rd_en                out  1       memory read strobe
//    mem_rd_addr              out  ADDR_W  physical read address
//    mem_rd_data              in   DATA_W  read data, valid 1 cycle after strobe
//    out_valid / out_ready    out/in       output stream handshake
//    out_data                 out  DATA_W  drained word
//    out_logical_addr         out  ADDR_W  logical index of out_data
//    out_last                 out  1       final word of the drain
//    busy                     out  1       drain in progress
//    done                     out  1       one-cycle pulse at end of drain
// ============================================================================
module tcn_fifo_drain_decoder #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              FIFO_TCN_active,
  input  logic [ADDR_W-1:0] FIFO_TCN_total_blocks,
  input  logic [15:0]       FIFO_TCN_block_size,
  input  logic              FIFO_TCN_update_pointer,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_logical_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  // Words that may be committed (read issued) but not yet accepted: one per
  // output buffer entry.
  localparam logic [1:0] c_MAX_OUTST = 2'd2;
  localparam logic [ADDR_W-1:0] c_ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;

  // Pointer tracking
  logic                r_upd_q;
  logic [ADDR_W-1:0]   r_ptr;

  // Drain snapshot and walk counters
  logic [ADDR_W-1:0]   r_n;        // ring size in words, frozen at start
  logic [ADDR_W-1:0]   r_addr;     // physical address of the next/current read
  logic [ADDR_W-1:0]   r_log;      // logical index of the next/current read
  logic [ADDR_W-1:0]   r_rem;      // reads still to issue
  logic [1:0]          r_outst;    // reads issued but words not yet accepted
  logic                r_busy;
  logic                r_done;

  // Read in flight: data returns the cycle after the strobe, so the logical
  // tag of that read is carried alongside for one cycle.
  logic                r_cap_vld;
  logic [ADDR_W-1:0]   r_cap_log;
  logic                r_cap_last;

  // Two-entry output buffer
  logic [DATA_W-1:0]   r_buf_data [2];
  logic [ADDR_W-1:0]   r_buf_log  [2];
  logic                r_buf_last [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;

  logic [ADDR_W-1:0]   w_bsize;
  logic [ADDR_W-1:0]   w_n;
  logic [ADDR_W-1:0]   w_cur;
  logic [ADDR_W-1:0]   w_p0;
  logic                w_accept;
  logic [1:0]          w_outst_after;
  logic                w_issue;

  // --------------------------------------------------------------------------
  // Start-time snapshot arithmetic. Everything is modulo 2**ADDR_W, so only
  // the low ADDR_W bits of the block size matter to the products.
  // --------------------------------------------------------------------------
  assign w_bsize = ADDR_W'(FIFO_TCN_block_size);
  assign w_n     = FIFO_TCN_total_blocks * w_bsize;
  assign w_cur   = FIFO_TCN_active ? (r_ptr * w_bsize) : c_ADDR_ZERO;
  // The encoder stores logical L at (L - cur) mod N, so logical 0 lives at N-cur.
  assign w_p0    = (w_cur == c_ADDR_ZERO) ? c_ADDR_ZERO : (w_n - w_cur);

  // --------------------------------------------------------------------------
  // Read credit. A word accepted this cycle frees its credit immediately, which
  // is what lets the stream sustain one word per cycle with only two entries.
  // --------------------------------------------------------------------------
  assign w_accept      = out_valid & out_ready;
  assign w_outst_after = r_outst - {1'b0, w_accept};
  assign w_issue       = (r_state == S_DRAIN) && (r_rem != c_ADDR_ZERO) &&
                         (w_outst_after < c_MAX_OUTST);

  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_addr;
  assign busy        = r_busy;
  assign done        = r_done;

  assign out_valid        = (r_count != 2'd0);
  assign out_data         = r_buf_data[r_rd_ptr];
  assign out_logical_addr = r_buf_log[r_rd_ptr];
  assign out_last         = r_buf_last[r_rd_ptr];

  // --------------------------------------------------------------------------
  // FIFO pointer: the update pulse is registered once, then the registered
  // pulse advances the pointer. It runs regardless of drain state; a drain in
  // progress only ever uses its start snapshot.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_upd_q <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_upd_q <= FIFO_TCN_update_pointer;
      if (r_upd_q) begin
        if (r_ptr == FIFO_TCN_total_blocks - c_ADDR_ONE)
          r_ptr <= '0;
        else
          r_ptr <= r_ptr + c_ADDR_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Drain control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_addr  <= '0;
      r_log   <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_DRAIN;
            r_busy  <= 1'b1;
            r_n     <= w_n;
            r_addr  <= w_p0;
            r_log   <= '0;
            r_rem   <= w_n;
          end
        end

        S_DRAIN: begin
          if (r_rem == c_ADDR_ZERO) begin
            // Only reachable with an empty ring: nothing to read or flush.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_issue) begin
            r_addr <= (r_addr == r_n - c_ADDR_ONE) ? c_ADDR_ZERO
                                                   : (r_addr + c_ADDR_ONE);
            r_log  <= r_log + c_ADDR_ONE;
            r_rem  <= r_rem - c_ADDR_ONE;
            if (r_rem == c_ADDR_ONE)
              r_state <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          // r_outst covers both the read in flight and buffered words.
          if (w_outst_after == 2'd0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Credit counter and in-flight read tag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outst    <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_log  <= '0;
      r_cap_last <= 1'b0;
    end else begin
      r_outst   <= w_outst_after + {1'b0, w_issue};
      r_cap_vld <= w_issue;
      if (w_issue) begin
        r_cap_log  <= r_log;
        r_cap_last <= (r_log == r_n - c_ADDR_ONE);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output buffer: push the returning read, pop on handshake. The head entry is
  // only rewritten after it is popped, so out_* hold while stalled.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_log[i]  <= '0;
        r_buf_last[i] <= 1'b0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (r_cap_vld) begin
        r_buf_data[r_wr_ptr] <= mem_rd_data;
        r_buf_log[r_wr_ptr]  <= r_cap_log;
        r_buf_last[r_wr_ptr] <= r_cap_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_accept)
        r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_cap_vld} - {1'b0, w_accept};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tcn_fifo_drain_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tcn_fifo_drain_decoder
//  Purpose  : Self-checking bench for tcn_fifo_drain_decoder. A table of
//             directed drain configurations plus randomized ones; the expected
//             stream comes from the ring-rotation formula applied to a memory
//             image held in the bench.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tcn_fifo_drain_decoder;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          FIFO_TCN_active;
  logic [AW-1:0] FIFO_TCN_total_blocks;
  logic [15:0]   FIFO_TCN_block_size;
  logic          FIFO_TCN_update_pointer;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_logical_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  tcn_fifo_drain_decoder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .FIFO_TCN_active         (FIFO_TCN_active),
    .FIFO_TCN_total_blocks   (FIFO_TCN_total_blocks),
    .FIFO_TCN_block_size     (FIFO_TCN_block_size),
    .FIFO_TCN_update_pointer (FIFO_TCN_update_pointer),
    .mem_rd_en               (mem_rd_en),
    .mem_rd_addr             (mem_rd_addr),
    .mem_rd_data             (mem_rd_data),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .out_data                (out_data),
    .out_logical_addr        (out_logical_addr),
    .out_last                (out_last),
    .busy                    (busy),
    .done                    (done)
  );

  // Synchronous-read activation memory; garbage on the bus when not reading.
  logic [DW-1:0] mem [MEMSZ];
  always @(posedge clk)
    mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : $urandom();

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] d;
    int            l;
    bit            last;
  } beat_t;

  int    m_ptr;
  int    exp_addr_q[$];
  beat_t exp_beat_q[$];

  // Encoder stores logical L at physical (L - cur) mod N; expected stream is
  // simply L = 0..N-1 read from that location.
  function automatic int build_model(input bit act, input int blocks, input int bsz);
    int n, cur, p;
    beat_t b;
    n   = (blocks * bsz) % MEMSZ;
    cur = act ? ((m_ptr * bsz) % MEMSZ) : 0;
    exp_addr_q.delete();
    exp_beat_q.delete();
    for (int l = 0; l < n; l++) begin
      p = (((l - cur) % n) + n) % n;
      exp_addr_q.push_back(p);
      b.d = mem[p];
      b.l = l;
      b.last = (l == n - 1);
      exp_beat_q.push_back(b);
    end
    return n;
  endfunction

  // ---------------- monitor ----------------
  bit          mon_en = 0;
  int          k, rd_cnt, acc_cnt, done_cnt, busy_cnt;
  int          first_rd_addr, first_valid_k, last_k, done_k;
  bit          prev_stall;
  logic [47:0] prev_bundle;

  task automatic mon_clear();
    k = 0; rd_cnt = 0; acc_cnt = 0; done_cnt = 0; busy_cnt = 0;
    first_rd_addr = -1; first_valid_k = -1; last_k = -1; done_k = -1;
    prev_stall = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      beat_t b;
      if (busy) busy_cnt++;
      if (mem_rd_en) begin
        if (rd_cnt == 0) first_rd_addr = int'(mem_rd_addr);
        rd_cnt++;
        if (exp_addr_q.size() == 0) chk("extra_read", 1, 0);
        else chk("rd_addr", 64'(mem_rd_addr), 64'(exp_addr_q.pop_front()));
      end
      if (prev_stall)
        chk("stall_hold", {16'b0, out_valid, out_data, out_logical_addr, out_last},
            {16'b0, prev_bundle});
      if (out_valid && first_valid_k < 0) first_valid_k = k;
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_beat_q.size() == 0) chk("extra_word", 1, 0);
        else begin
          b = exp_beat_q.pop_front();
          chk("out_data", 64'(out_data), 64'(b.d));
          chk("out_laddr", 64'(out_logical_addr), 64'(b.l));
          chk("out_last", 64'(out_last), 64'(b.last));
        end
        if (out_last) last_k = k;
      end
      chk("outstanding_le2", 64'(rd_cnt - acc_cnt <= 2), 1);
      if (done) begin done_cnt++; done_k = k; end
      prev_stall  = out_valid && !out_ready;
      prev_bundle = {out_valid, out_data, out_logical_addr, out_last};
      k++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, {18'b0, mem_rd_en, mem_rd_addr, out_valid, out_logical_addr,
                         out_last, busy, done}, 64'd0);
    chk({name, "_data"}, 64'(out_data), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    m_ptr = 0;
    tick();
  endtask

  task automatic pulse_ptr(input int blocks);
    FIFO_TCN_update_pointer = 1'b1;
    tick();
    FIFO_TCN_update_pointer = 1'b0;
    m_ptr = (m_ptr == blocks - 1) ? 0 : m_ptr + 1;
    tick(); tick();
  endtask

  typedef struct {
    bit rst_first;
    bit active;
    int blocks;
    int bsize;
    int pulses;
    int ready_mode;    // 0: always ready, 1: 1,0,0 pattern, 2: random
    bit second_start;
    int abort_after;   // accepted words before async reset, -1: none
    int exp_first;     // expected first physical read address, -1: skip
    int exp_reads;     // expected read count, -1: skip
    int exp_last_k;    // cycles from start edge to last word, -1: skip
  } vec_t;

  task automatic run_vec(input vec_t v);
    int  n;
    bit  finished;
    if (v.rst_first) do_reset();
    FIFO_TCN_active       = v.active;
    FIFO_TCN_total_blocks = AW'(v.blocks);
    FIFO_TCN_block_size   = 16'(v.bsize);
    tick();
    for (int i = 0; i < v.pulses; i++) pulse_ptr(v.blocks);
    n = build_model(v.active, v.blocks, v.bsize);

    start = 1'b1;
    tick();
    start = 1'b0;
    mon_clear();
    mon_en = 1'b1;
    finished = 1'b0;
    for (int c = 0; c < 400; c++) begin
      case (v.ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 3 == 0);
        default: out_ready = ($urandom_range(3) != 0);
      endcase
      start = v.second_start && (c == 4);
      if (v.abort_after >= 0 && acc_cnt >= v.abort_after) begin finished = 1'b1; break; end
      if (done_cnt > 0) begin finished = 1'b1; break; end
      tick();
    end
    start = 1'b0;
    if (!finished) chk("timeout", 0, 1);

    if (v.abort_after >= 0) begin
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      check_zero("abort_zero");
      tick(); tick();
      reset = 1'b1;
      m_ptr = 0;
      exp_addr_q.delete();
      exp_beat_q.delete();
      tick(); tick();
      chk("abort_no_done", {62'b0, done, busy}, 64'd0);
      return;
    end

    out_ready = 1'b1;
    repeat (4) tick();
    mon_en = 1'b0;
    chk("rd_count_model", 64'(rd_cnt), 64'(n));
    chk("acc_count", 64'(acc_cnt), 64'(n));
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("model_drained", 64'(exp_beat_q.size() + exp_addr_q.size()), 64'd0);
    if (v.exp_reads >= 0) chk("rd_count_table", 64'(rd_cnt), 64'(v.exp_reads));
    if (v.exp_first >= 0) chk("first_addr", 64'(first_rd_addr), 64'(v.exp_first));
    if (v.exp_last_k >= 0) begin
      chk("first_valid_lat", 64'(first_valid_k), 64'd2);
      chk("last_lat", 64'(last_k), 64'(v.exp_last_k));
      chk("done_lat", 64'(done_k), 64'(v.exp_last_k + 1));
    end
    if (n == 0) begin
      chk("empty_busy_cycles", 64'(busy_cnt), 64'd1);
      chk("empty_no_valid", 64'(first_valid_k), 64'hFFFF_FFFF_FFFF_FFFF);
    end
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MEMSZ; i++)
      mem[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;

    //            rst act blk bs pls rdy 2nd abort first reads lastk
    tbl[0] = '{1'b1, 1'b1, 4, 3, 1, 0, 1'b0, -1,  9, 12, 13};
    tbl[1] = '{1'b0, 1'b0, 4, 3, 0, 0, 1'b0, -1,  0, 12, 13};
    tbl[2] = '{1'b1, 1'b1, 4, 3, 4, 0, 1'b0, -1,  0, 12, 13};
    tbl[3] = '{1'b1, 1'b1, 4, 3, 1, 1, 1'b0, -1,  9, 12, -1};
    tbl[4] = '{1'b0, 1'b1, 0, 3, 0, 0, 1'b0, -1, -1,  0, -1};
    tbl[5] = '{1'b1, 1'b1, 5, 2, 2, 0, 1'b1, -1,  6, 10, 11};
    tbl[6] = '{1'b1, 1'b1, 4, 3, 1, 0, 1'b0,  5, -1, -1, -1};
    tbl[7] = '{1'b0, 1'b1, 4, 3, 0, 0, 1'b0, -1,  0, 12, 13};

    reset = 1'b0;
    start = 1'b0;
    FIFO_TCN_active = 1'b0;
    FIFO_TCN_total_blocks = '0;
    FIFO_TCN_block_size = '0;
    FIFO_TCN_update_pointer = 1'b0;
    out_ready = 1'b0;
    m_ptr = 0;
    tick();
    check_zero("reset_state");
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      rv.rst_first    = 1'b1;
      rv.active       = 1'($urandom_range(1));
      rv.blocks       = int'($urandom_range(8, 1));
      rv.bsize        = int'($urandom_range(5, 1));
      rv.pulses       = int'($urandom_range(6));
      rv.ready_mode   = int'($urandom_range(2));
      rv.second_start = 1'($urandom_range(1));
      rv.abort_after  = -1;
      rv.exp_first    = -1;
      rv.exp_reads    = -1;
      rv.exp_last_k   = -1;
      run_vec(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
